icache_2way: RTL and testbench



---
 rtl/icache_2way_if.sv | 27 ++
 rtl/icache_2way.sv | 148 ++++++++++++++
 tb/tb_icache_2way.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_2way_if.sv
// Port bundle for icache_2way: the IF-stage fetch port plus the AXI bridge icache read port.
// The cache takes the slave side; the fetch stage and bridge together take the master side.
interface icache_2way_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        icache_rd_req;
    logic [2:0]  icache_rd_type;
    logic [31:0] icache_rd_addr;
    logic        icache_rd_rdy;
    logic        icache_ret_valid;
    logic        icache_ret_last;
    logic [31:0] icache_ret_data;

    modport master (
        output inst_req, inst_addr, icache_rd_rdy, icache_ret_valid, icache_ret_last, icache_ret_data,
        input  inst_addr_ok, inst_data_ok, inst_rdata, icache_rd_req, icache_rd_type, icache_rd_addr
    );

    modport slave (
        input  inst_req, inst_addr, icache_rd_rdy, icache_ret_valid, icache_ret_last, icache_ret_data,
        output inst_addr_ok, inst_data_ok, inst_rdata, icache_rd_req, icache_rd_type, icache_rd_addr
    );
endinterface

// File: rtl/icache_2way.sv
// 2-way set-associative read-only instruction cache, 16-byte lines, LRU replacement.
// Hits return from a registered lookup stage; misses fetch one 4-beat line from the bridge.
module icache_2way #(
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 4
) (
    input logic          aclk,
    input logic          aresetn,
    icache_2way_if.slave bus
);
    localparam int TAG_W = 32 - INDEX_W - OFFSET_W;
    localparam int SETS  = 1 << INDEX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, RESP} state_e;

    state_e      state_q, state_d;
    logic [31:2] reqAddr_q, reqAddr_d;
    logic        victim_q, victim_d;
    logic [1:0]  beatCnt_q, beatCnt_d;

    logic [SETS-1:0]  valid_q [2];
    logic [SETS-1:0]  lru_q;
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [31:0]      data_q  [2][SETS][4];

    logic [TAG_W-1:0]   reqTag;
    logic [INDEX_W-1:0] reqIdx;
    logic [1:0]         reqWord;
    logic               hit0, hit1, hit, hitWay;
    logic               addrOk, dataOk, rdReq;
    logic [31:0]        rdata;
    logic               refillBeat, refillLast;

    assign reqTag  = reqAddr_q[31 -: TAG_W];
    assign reqIdx  = reqAddr_q[OFFSET_W +: INDEX_W];
    assign reqWord = reqAddr_q[3:2];

    assign hit0   = valid_q[0][reqIdx] && (tag_q[0][reqIdx] == reqTag);
    assign hit1   = valid_q[1][reqIdx] && (tag_q[1][reqIdx] == reqTag);
    assign hit    = hit0 | hit1;
    assign hitWay = hit1;

    assign refillBeat = (state_q == REFILL) && bus.icache_ret_valid;
    assign refillLast = refillBeat && bus.icache_ret_last;

    always_comb begin
        state_d   = state_q;
        reqAddr_d = reqAddr_q;
        victim_d  = victim_q;
        beatCnt_d = beatCnt_q;
        addrOk    = 1'b0;
        dataOk    = 1'b0;
        rdReq     = 1'b0;
        rdata     = '0;
        case (state_q)
            IDLE: begin
                addrOk = 1'b1;
                if (bus.inst_req) begin
                    reqAddr_d = bus.inst_addr[31:2];
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    dataOk = 1'b1;
                    rdata  = data_q[hitWay][reqIdx][reqWord];
                    addrOk = 1'b1;
                    if (bus.inst_req) begin
                        reqAddr_d = bus.inst_addr[31:2];
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    // Fill empty ways before evicting anything.
                    victim_d = !valid_q[0][reqIdx] ? 1'b0 :
                               (!valid_q[1][reqIdx] ? 1'b1 : lru_q[reqIdx]);
                    state_d  = MISS;
                end
            end
            MISS: begin
                rdReq = 1'b1;
                if (bus.icache_rd_rdy) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (refillBeat) begin
                    beatCnt_d = beatCnt_q + 2'd1;
                    if (bus.icache_ret_last) begin
                        beatCnt_d = 2'd0;
                        state_d   = RESP;
                    end
                end
            end
            RESP: begin
                dataOk  = 1'b1;
                rdata   = data_q[victim_q][reqIdx][reqWord];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            reqAddr_q  <= '0;
            victim_q   <= 1'b0;
            beatCnt_q  <= 2'd0;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            state_q   <= state_d;
            reqAddr_q <= reqAddr_d;
            victim_q  <= victim_d;
            beatCnt_q <= beatCnt_d;
            if ((state_q == LOOKUP) && hit) begin
                lru_q[reqIdx] <= ~hitWay;
            end
            // Invalidate the victim up front so a half-written line can never hit.
            if ((state_q == MISS) && bus.icache_rd_rdy) begin
                valid_q[victim_q][reqIdx] <= 1'b0;
            end
            if (refillLast) begin
                valid_q[victim_q][reqIdx] <= 1'b1;
                lru_q[reqIdx]             <= ~victim_q;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (refillBeat) begin
            data_q[victim_q][reqIdx][beatCnt_q] <= bus.icache_ret_data;
        end
        if (refillLast) begin
            tag_q[victim_q][reqIdx] <= reqTag;
        end
    end

    // No fetch is accepted while reset is held.
    assign bus.inst_addr_ok   = addrOk & aresetn;
    assign bus.inst_data_ok   = dataOk;
    assign bus.inst_rdata     = rdata;
    assign bus.icache_rd_req  = rdReq;
    assign bus.icache_rd_type = 3'b100;
    assign bus.icache_rd_addr = rdReq ? {reqTag, reqIdx, {OFFSET_W{1'b0}}} : '0;
endmodule

// File: tb/tb_icache_2way.sv
// Self-checking bench for icache_2way: directed scenarios plus randomized fetches
// checked against a set/way/LRU reference model and a fixed memory image.
module tb_icache_2way;
    logic aclk = 1'b0;
    logic aresetn;

    icache_2way_if bus();

    icache_2way dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    int numChecks = 0;
    int numFails  = 0;

    bit          mValid [2][64];
    logic [21:0] mTag   [2][64];
    int          mLru   [64];

    // Backing memory: line 0x1C00_0000 holds 0xA0..0xA3, everything else a hash of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w[31:4] == 28'h1C0_0000) return 32'hA0 + {30'd0, w[3:2]};
        return {w[15:0], ~w[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic void modelReset();
        for (int s = 0; s < 64; s++) begin
            mValid[0][s] = 1'b0;
            mValid[1][s] = 1'b0;
            mLru[s]      = 0;
        end
    endfunction

    // Returns 1 on hit; updates contents and the way-to-evict-next.
    function automatic bit modelAccess(input logic [31:0] a);
        int          idx;
        int          v;
        logic [21:0] t;
        idx = int'(a[9:4]);
        t   = a[31:10];
        for (int w = 0; w < 2; w++) begin
            if (mValid[w][idx] && mTag[w][idx] == t) begin
                mLru[idx] = 1 - w;
                return 1'b1;
            end
        end
        if (!mValid[0][idx])      v = 0;
        else if (!mValid[1][idx]) v = 1;
        else                      v = mLru[idx];
        mValid[v][idx] = 1'b1;
        mTag[v][idx]   = t;
        mLru[idx]      = 1 - v;
        return 1'b0;
    endfunction

    task automatic doFetch(input logic [31:0] addr, input int stall, input int abortAfter,
                           input bit holdReq, input bit randGaps, output bit wasHit);
        logic [31:0] line;
        bit          expHit;
        int          waited;
        int          handshakes;
        int          gap;
        line       = {addr[31:4], 4'b0000};
        wasHit     = 1'b0;
        handshakes = 0;
        @(negedge aclk);
        bus.inst_req  = 1'b1;
        bus.inst_addr = addr;
        #1;
        waited = 0;
        while (bus.inst_addr_ok !== 1'b1 && waited < 20) begin
            @(negedge aclk);
            #1;
            waited++;
        end
        numChecks++;
        if (bus.inst_addr_ok !== 1'b1) begin
            numFails++;
            $display("[TB] FAIL accept %h: addr_ok=%b expected 1", addr, bus.inst_addr_ok);
            bus.inst_req = 1'b0;
            return;
        end
        expHit = modelAccess(addr);
        @(negedge aclk);
        if (!holdReq) bus.inst_req = 1'b0;
        #1;
        wasHit = (bus.inst_data_ok === 1'b1);
        numChecks++;
        if (wasHit !== expHit) begin
            numFails++;
            $display("[TB] FAIL hit/miss %h: got hit=%b expected %b", addr, wasHit, expHit);
        end
        if (wasHit) begin
            numChecks++;
            if (bus.inst_rdata !== memWord(addr)) begin
                numFails++;
                $display("[TB] FAIL hit rdata %h: got %h expected %h", addr, bus.inst_rdata, memWord(addr));
            end
            return;
        end
        numChecks++;
        if (bus.inst_addr_ok !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL miss addr_ok %h: got %b expected 0", addr, bus.inst_addr_ok);
        end
        for (int s = 0; s <= stall; s++) begin
            @(negedge aclk);
            bus.icache_rd_rdy    = (s == stall);
            bus.icache_ret_valid = randGaps && (s < stall);
            bus.icache_ret_data  = 32'hDEAD_BEEF;
            #1;
            numChecks++;
            if (bus.icache_rd_req !== 1'b1 || bus.icache_rd_addr !== line || bus.icache_rd_type !== 3'b100) begin
                numFails++;
                $display("[TB] FAIL miss request %h cycle %0d: got req=%b addr=%h type=%b expected 1 %h 100",
                         addr, s, bus.icache_rd_req, bus.icache_rd_addr, bus.icache_rd_type, line);
            end
            if (holdReq) begin
                numChecks++;
                if (bus.inst_addr_ok !== 1'b0) begin
                    numFails++;
                    $display("[TB] FAIL held addr_ok in MISS: got %b expected 0", bus.inst_addr_ok);
                end
            end
            if (bus.icache_rd_req === 1'b1 && bus.icache_rd_rdy) handshakes++;
        end
        for (int b = 0; b < 4; b++) begin
            gap = randGaps ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gap; g++) begin
                @(negedge aclk);
                bus.icache_rd_rdy    = 1'b0;
                bus.icache_ret_valid = 1'b0;
                #1;
                numChecks++;
                if (bus.icache_rd_req !== 1'b0 || bus.inst_data_ok !== 1'b0) begin
                    numFails++;
                    $display("[TB] FAIL refill gap: got rd_req=%b data_ok=%b expected 0 0",
                             bus.icache_rd_req, bus.inst_data_ok);
                end
            end
            @(negedge aclk);
            bus.icache_rd_rdy    = 1'b0;
            bus.icache_ret_valid = 1'b1;
            bus.icache_ret_data  = memWord({line[31:4], 2'(b), 2'b00});
            bus.icache_ret_last  = (b == 3);
            #1;
            numChecks++;
            if (bus.icache_rd_req !== 1'b0) begin
                numFails++;
                $display("[TB] FAIL refill rd_req beat %0d: got %b expected 0", b, bus.icache_rd_req);
            end
            if (holdReq) begin
                numChecks++;
                if (bus.inst_addr_ok !== 1'b0) begin
                    numFails++;
                    $display("[TB] FAIL held addr_ok in REFILL: got %b expected 0", bus.inst_addr_ok);
                end
            end
            if (b + 1 == abortAfter) begin
                @(negedge aclk);
                bus.icache_ret_valid = 1'b0;
                bus.icache_ret_last  = 1'b0;
                aresetn              = 1'b0;
                @(negedge aclk);
                #1;
                numChecks++;
                if (bus.icache_rd_req !== 1'b0 || bus.inst_data_ok !== 1'b0 || bus.inst_addr_ok !== 1'b0) begin
                    numFails++;
                    $display("[TB] FAIL reset in refill: got rd_req=%b data_ok=%b addr_ok=%b expected 0 0 0",
                             bus.icache_rd_req, bus.inst_data_ok, bus.inst_addr_ok);
                end
                @(negedge aclk);
                aresetn = 1'b1;
                #1;
                numChecks++;
                if (bus.inst_addr_ok !== 1'b1) begin
                    numFails++;
                    $display("[TB] FAIL idle after reset: addr_ok=%b expected 1", bus.inst_addr_ok);
                end
                modelReset();
                return;
            end
        end
        @(negedge aclk);
        bus.icache_ret_valid = 1'b0;
        bus.icache_ret_last  = 1'b0;
        #1;
        numChecks++;
        if (bus.inst_data_ok !== 1'b1 || bus.inst_rdata !== memWord(addr)) begin
            numFails++;
            $display("[TB] FAIL miss response %h: got data_ok=%b rdata=%h expected 1 %h",
                     addr, bus.inst_data_ok, bus.inst_rdata, memWord(addr));
        end
        if (holdReq) begin
            numChecks++;
            if (bus.inst_addr_ok !== 1'b0) begin
                numFails++;
                $display("[TB] FAIL held addr_ok in RESP: got %b expected 0", bus.inst_addr_ok);
            end
        end
        numChecks++;
        if (handshakes != 1) begin
            numFails++;
            $display("[TB] FAIL handshake count: got %0d expected 1", handshakes);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        numChecks++;
        if (bus.inst_addr_ok !== 1'b0 || bus.inst_data_ok !== 1'b0 || bus.inst_rdata !== 32'd0) begin
            numFails++;
            $display("[TB] FAIL reset fetch outputs: got %b %b %h expected 0 0 0",
                     bus.inst_addr_ok, bus.inst_data_ok, bus.inst_rdata);
        end
        numChecks++;
        if (bus.icache_rd_req !== 1'b0 || bus.icache_rd_addr !== 32'd0 || bus.icache_rd_type !== 3'b100) begin
            numFails++;
            $display("[TB] FAIL reset bridge outputs: got %b %h %b expected 0 0 100",
                     bus.icache_rd_req, bus.icache_rd_addr, bus.icache_rd_type);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        numChecks++;
        if (bus.inst_addr_ok !== 1'b1) begin
            numFails++;
            $display("[TB] FAIL idle addr_ok: got %b expected 1", bus.inst_addr_ok);
        end
        modelReset();
    endtask

    task automatic test_cold_miss();
        bit h;
        doFetch(32'h1C00_0004, 0, -1, 1'b0, 1'b0, h);
        numChecks++;
        if (h !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL cold miss: got hit=%b expected 0", h);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] expData [3];
        addrs   = '{32'h1C00_0000, 32'h1C00_0008, 32'h1C00_000C};
        expData = '{32'h0000_00A0, 32'h0000_00A2, 32'h0000_00A3};
        @(negedge aclk);
        bus.inst_req  = 1'b1;
        bus.inst_addr = addrs[0];
        #1;
        numChecks++;
        if (bus.inst_addr_ok !== 1'b1) begin
            numFails++;
            $display("[TB] FAIL b2b accept 0: got %b expected 1", bus.inst_addr_ok);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge aclk);
            if (i < 3) bus.inst_addr = addrs[i];
            else       bus.inst_req  = 1'b0;
            #1;
            void'(modelAccess(addrs[i-1]));
            numChecks++;
            if (bus.inst_data_ok !== 1'b1 || bus.inst_rdata !== expData[i-1] || bus.icache_rd_req !== 1'b0) begin
                numFails++;
                $display("[TB] FAIL b2b hit %0d: got data_ok=%b rdata=%h rd_req=%b expected 1 %h 0",
                         i - 1, bus.inst_data_ok, bus.inst_rdata, bus.icache_rd_req, expData[i-1]);
            end
            if (i < 3) begin
                numChecks++;
                if (bus.inst_addr_ok !== 1'b1) begin
                    numFails++;
                    $display("[TB] FAIL b2b accept %0d: got %b expected 1", i, bus.inst_addr_ok);
                end
            end
        end
        @(negedge aclk);
        #1;
        numChecks++;
        if (bus.inst_data_ok !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL b2b extra data_ok: got %b expected 0", bus.inst_data_ok);
        end
    endtask

    task automatic test_lru();
        logic [31:0] seq [6];
        bit          expHit [6];
        bit          h;
        seq    = '{32'h2000_0000, 32'h3000_0004, 32'h2000_0008, 32'h4000_0000, 32'h2000_0004, 32'h3000_000C};
        expHit = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            doFetch(seq[i], 0, -1, 1'b0, 1'b0, h);
            numChecks++;
            if (h !== expHit[i]) begin
                numFails++;
                $display("[TB] FAIL lru step %0d (%h): got hit=%b expected %b", i, seq[i], h, expHit[i]);
            end
        end
    endtask

    task automatic test_rd_stall();
        bit h;
        doFetch(32'h1C00_1234, 5, -1, 1'b0, 1'b0, h);
        numChecks++;
        if (h !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL stall fetch: got hit=%b expected 0", h);
        end
    endtask

    task automatic test_reset_refill();
        bit h;
        doFetch(32'h5000_0048, 0, 2, 1'b0, 1'b0, h);
        doFetch(32'h5000_0048, 0, -1, 1'b0, 1'b0, h);
        numChecks++;
        if (h !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL refetch after reset: got hit=%b expected 0", h);
        end
    endtask

    task automatic test_hold_req();
        bit h;
        doFetch(32'h6000_0050, 0, -1, 1'b0, 1'b0, h);
        doFetch(32'h7000_0050, 0, -1, 1'b0, 1'b0, h);
        doFetch(32'h8000_0054, 1, -1, 1'b1, 1'b0, h);
        numChecks++;
        if (h !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL hold miss: got hit=%b expected 0", h);
        end
        @(negedge aclk);
        #1;
        numChecks++;
        if (bus.inst_addr_ok !== 1'b1) begin
            numFails++;
            $display("[TB] FAIL hold re-accept: got addr_ok=%b expected 1", bus.inst_addr_ok);
        end
        void'(modelAccess(32'h8000_0054));
        @(negedge aclk);
        bus.inst_req = 1'b0;
        #1;
        numChecks++;
        if (bus.inst_data_ok !== 1'b1 || bus.inst_rdata !== memWord(32'h8000_0054)) begin
            numFails++;
            $display("[TB] FAIL hold re-fetch: got data_ok=%b rdata=%h expected 1 %h",
                     bus.inst_data_ok, bus.inst_rdata, memWord(32'h8000_0054));
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [21:0] t;
        logic [5:0]  idx;
        bit          h;
        for (int n = 0; n < 80; n++) begin
            t   = 22'h2A_0000 + 22'($urandom_range(0, 4));
            idx = 6'($urandom_range(0, 3));
            a   = {t, idx, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            doFetch(a, int'($urandom_range(0, 3)), -1, 1'b0, 1'b1, h);
        end
    endtask

    initial begin
        aresetn              = 1'b0;
        bus.inst_req         = 1'b0;
        bus.inst_addr        = '0;
        bus.icache_rd_rdy    = 1'b0;
        bus.icache_ret_valid = 1'b0;
        bus.icache_ret_last  = 1'b0;
        bus.icache_ret_data  = '0;
        modelReset();
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_lru();
        test_rd_stall();
        test_reset_refill();
        test_hold_req();
        test_random();
        repeat (2) @(negedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
